// File: rtl/riscv_instr_encoder.sv
// Packs RV32I instruction fields into 32-bit words and streams them with byte addresses to the imem loader.
// Latency: 1 cycle from input acceptance to out_valid; 1 word/cycle sustained while out_ready is held high.
// Backpressure: single registered output stage; in_ready drops while a word is held and out_ready is low.
module riscv_instr_encoder #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              imm_err,
    output logic              fmt_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_pending;
    logic                r_out_last;
    logic                r_out_valid;
    logic [31:0]         r_out_instr;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_imm_err;
    logic                r_fmt_err;

    logic                w_start;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_instr;
    logic                w_imm_bad;
    logic                w_fmt_bad;

    // start only matters in IDLE; a pulse in RUN or DONE is dropped here
    assign w_start   = start && (r_state == S_IDLE);
    assign w_pop     = r_out_valid && out_ready;
    assign in_ready  = (r_state == S_RUN) && !r_last_pending && (!r_out_valid || out_ready);
    assign w_push    = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign imm_err   = r_imm_err;
    assign fmt_err   = r_fmt_err;
    assign done      = (r_state == S_DONE);

    // Field packing plus immediate range/alignment checks (out-of-range bits are simply truncated)
    always_comb begin
        w_instr   = NOP;
        w_imm_bad = 1'b0;
        w_fmt_bad = 1'b0;
        case (in_fmt)
            3'd0: w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                w_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_imm_bad = !((&in_imm[31:11]) || (~|in_imm[31:11]));
            end
            3'd2: begin
                w_instr   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_imm_bad = !((&in_imm[31:11]) || (~|in_imm[31:11]));
            end
            3'd3: begin
                w_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                w_imm_bad = !((&in_imm[31:12]) || (~|in_imm[31:12])) || in_imm[0];
            end
            3'd4: begin
                w_instr   = {in_imm[31:12], in_rd, in_opcode};
                w_imm_bad = |in_imm[11:0];
            end
            3'd5: begin
                w_instr   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_imm_bad = !((&in_imm[31:20]) || (~|in_imm[31:20])) || in_imm[0];
            end
            default: w_fmt_bad = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: RUN ends when the word that carried in_last leaves the output stage
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_pop && r_out_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output stage, address counter, last tracking and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_addr     <= '0;
            r_out_last     <= 1'b0;
            r_last_pending <= 1'b0;
            r_addr         <= BASE_ADDR;
            r_imm_err      <= 1'b0;
            r_fmt_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr         <= BASE_ADDR;
                r_imm_err      <= 1'b0;
                r_fmt_err      <= 1'b0;
                r_last_pending <= 1'b0;
            end
            // A push in the same cycle as a pop simply overwrites the departing word
            if (w_push) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= r_addr;
                r_addr      <= r_addr + ADDR_W'(4);
                r_out_last  <= in_last;
                if (in_last)   r_last_pending <= 1'b1;
                if (w_imm_bad) r_imm_err      <= 1'b1;
                if (w_fmt_bad) r_fmt_err      <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            if (r_state == S_DONE) r_last_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Directed bench for riscv_instr_encoder: main instance at default params plus a 4-bit-address instance.
// Both instances share all inputs, so their handshakes track; only the address path differs.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there as well.
module tb_riscv_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, done, imm_err, fmt_err;
    logic [31:0] out_instr;
    logic [31:0] out_addr;

    logic        wr_in_ready, wr_out_valid, wr_done, wr_imm_err, wr_fmt_err;
    logic [31:0] wr_out_instr;
    logic [3:0]  wr_out_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    riscv_instr_encoder u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .done(done), .imm_err(imm_err), .fmt_err(fmt_err)
    );

    riscv_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(wr_in_ready),
        .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7),
        .in_imm(in_imm), .out_valid(wr_out_valid), .out_ready(out_ready), .out_instr(wr_out_instr),
        .out_addr(wr_out_addr), .done(wr_done), .imm_err(wr_imm_err), .fmt_err(wr_fmt_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [6:0] f7, input logic [31:0] imm, input logic last);
        in_fmt = f; in_opcode = op; in_rd = rd; in_funct3 = f3;
        in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_imm = imm; in_last = last;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            if (done) break;
            tick();
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL done_pulse: done=%b required 1 within 20 cycles", done);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_single: done=%b required 0 one cycle later", done);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_valid, done, imm_err, fmt_err, in_ready} !== 5'b0)
            $display("FAIL reset_flags: {ov,done,ie,fe,ir}=%b required 00000",
                     {out_valid, done, imm_err, fmt_err, in_ready});
        else n_pass++;
        n_checks++;
        if (out_instr !== 32'h0 || out_addr !== 32'h0)
            $display("FAIL reset_data: instr=%h addr=%h required 0/0", out_instr, out_addr);
        else n_pass++;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL idle_in_ready: in_ready=%b required 0", in_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        do_start();
        out_ready = 1'b1;
        set_fields(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b1);
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL single_in_ready: in_ready=%b required 1", in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_addr !== 32'd0)
            $display("FAIL single_word: ov=%b instr=%h addr=%h required 1/00500093/0",
                     out_valid, out_instr, out_addr);
        else n_pass++;
        wait_done();
    endtask

    function automatic logic [31:0] b2b_exp(input int i);
        case (i)
            0:       return 32'h002081B3;
            1:       return 32'h0020A423;
            2:       return 32'hFE208EE3;
            3:       return 32'h123452B7;
            default: return 32'h001000EF;
        endcase
    endfunction

    task automatic test_back_to_back();
        do_start();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_fields(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b0);
                1: set_fields(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0);
                2: set_fields(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC, 1'b0);
                3: set_fields(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1'b0);
                default: set_fields(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b1);
            endcase
            in_valid = 1'b1;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_instr !== b2b_exp(i) || out_addr !== 32'(4 * i))
                $display("FAIL b2b_word%0d: ov=%b instr=%h addr=%0d required 1/%h/%0d",
                         i, out_valid, out_instr, out_addr, b2b_exp(i), 4 * i);
            else n_pass++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (imm_err !== 1'b0) $display("FAIL b2b_no_err: imm_err=%b required 0", imm_err);
        else n_pass++;
        wait_done();
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_after_done: in_ready=%b required 0", in_ready);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_start();
        out_ready = 1'b0;
        set_fields(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b0);
        in_valid = 1'b1;
        tick();
        set_fields(3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h00100113 ||
                out_addr !== 32'd0)
                $display("FAIL bp_hold%0d: ir=%b ov=%b instr=%h addr=%0d required 0/1/00100113/0",
                         c, in_ready, out_valid, out_instr, out_addr);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00200193 || out_addr !== 32'd4)
            $display("FAIL bp_second: ov=%b instr=%h addr=%0d required 1/00200193/4",
                     out_valid, out_instr, out_addr);
        else n_pass++;
        wait_done();
    endtask

    task automatic test_errors();
        do_start();
        out_ready = 1'b1;
        set_fields(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b0);
        in_valid = 1'b1;
        tick();
        n_checks++;
        if (out_instr !== 32'h80000093 || imm_err !== 1'b1 || fmt_err !== 1'b0)
            $display("FAIL err_i2048: instr=%h ie=%b fe=%b required 80000093/1/0",
                     out_instr, imm_err, fmt_err);
        else n_pass++;
        set_fields(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 1'b0);
        tick();
        n_checks++;
        if (out_instr !== 32'h00000163 || imm_err !== 1'b1 || out_addr !== 32'd4)
            $display("FAIL err_b3: instr=%h ie=%b addr=%0d required 00000163/1/4",
                     out_instr, imm_err, out_addr);
        else n_pass++;
        set_fields(3'd7, 7'h33, 5'd9, 3'd1, 5'd2, 5'd3, 7'd0, 32'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_instr !== 32'h00000013 || fmt_err !== 1'b1 || out_addr !== 32'd8)
            $display("FAIL err_fmt7: instr=%h fe=%b addr=%0d required 00000013/1/8",
                     out_instr, fmt_err, out_addr);
        else n_pass++;
        wait_done();
        do_start();
        n_checks++;
        if (imm_err !== 1'b0 || fmt_err !== 1'b0)
            $display("FAIL err_clear: ie=%b fe=%b required 0/0", imm_err, fmt_err);
        else n_pass++;
        set_fields(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFF800, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_instr !== 32'h80000093 || imm_err !== 1'b0)
            $display("FAIL err_i_neg2048: instr=%h ie=%b required 80000093/0", out_instr, imm_err);
        else n_pass++;
        wait_done();
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        do_start();
        out_ready = 1'b0;
        set_fields(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rmid_pre: out_valid=%b required 1", out_valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, done, imm_err, fmt_err, in_ready} !== 5'b0 || out_instr !== 32'h0 ||
            out_addr !== 32'h0)
            $display("FAIL rmid_clear: flags=%b instr=%h addr=%h required 00000/0/0",
                     {out_valid, done, imm_err, fmt_err, in_ready}, out_instr, out_addr);
        else n_pass++;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen_done = seen_done | done;
            tick();
        end
        n_checks++;
        if (seen_done !== 1'b0) $display("FAIL rmid_no_done: done seen=%b required 0", seen_done);
        else n_pass++;
        do_start();
        set_fields(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_instr !== 32'h00100113 || out_addr !== 32'd0)
            $display("FAIL rmid_restart: instr=%h addr=%0d required 00100113/0", out_instr, out_addr);
        else n_pass++;
        wait_done();
    endtask

    task automatic test_start_in_run_and_wrap();
        do_start();
        out_ready = 1'b1;
        set_fields(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_addr !== 32'd0 || wr_out_addr !== 4'd12)
            $display("FAIL run_first: addr=%0d wrap_addr=%0d required 0/12", out_addr, wr_out_addr);
        else n_pass++;
        do_start();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL run_start_ignored: in_ready=%b required 1", in_ready);
        else n_pass++;
        set_fields(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_instr !== 32'h00100113 || out_addr !== 32'd4 || wr_out_addr !== 4'd0)
            $display("FAIL run_second: instr=%h addr=%0d wrap_addr=%0d required 00100113/4/0",
                     out_instr, out_addr, wr_out_addr);
        else n_pass++;
        wait_done();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_start_in_run_and_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
